// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM state encoding and the default frame length.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} uart_arb_state_t;

  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin requester pick for the UART arbiter. The search starts at rr_ptr and wraps.
// Purely combinational (0 cycles). It never stalls; the caller decides when a pick is accepted.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] pick_oh,
  output logic [IW-1:0]   pick_idx,
  output logic            any_valid
);

  // The outer loop sets the search order and the inner loop finds the matching index.
  // This keeps every bit select a constant.
  always_comb begin
    pick_oh   = '0;
    pick_idx  = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any_valid && req[i] && (i == (int'(rr_ptr) + k) % NREQ)) begin
          pick_oh[i] = 1'b1;
          pick_idx   = IW'(i);
          any_valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single UART transmitter. Grant in the request cycle; LOAD, START, then a full frame wait.
// One byte per FRAME_CYCLES+3 cycles. req_ready is held low outside IDLE, so requesters wait.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int CLKS_PER_BIT = 868,
  parameter int FRAME_BITS   = UART_FRAME_BITS,
  localparam int IW           = $clog2(NREQ),
  localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS,
  localparam int CW           = $clog2(FRAME_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              uart_sel,
  output logic              wr,
  output logic [7:0]        data_out,
  output logic              byte_ready,
  output logic              t_byte,
  output logic              busy,
  output logic              tx_done,
  output logic [IW-1:0]     grant_id
);

  uart_arb_state_t state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, pick_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      data_reg_q, data_reg_d, data_out_q, data_out_d, pick_data;
  logic [NREQ-1:0] pick_oh;
  logic            any_valid, hs;
  logic            uart_sel_q, uart_sel_d, wr_q, wr_d, byte_ready_q, byte_ready_d;
  logic            t_byte_q, t_byte_d, busy_q, busy_d, tx_done_q, tx_done_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .pick_oh   (pick_oh),
    .pick_idx  (pick_idx),
    .any_valid (any_valid)
  );

  // Gating with rst keeps req_ready low while reset is asserted, even though state_q already reads IDLE.
  assign req_ready = (rst && state_q == IDLE) ? pick_oh : '0;
  assign hs        = (state_q == IDLE) && any_valid;

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) pick_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    data_reg_d = data_reg_q;
    cnt_d      = '0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d    = LOAD;
          data_reg_d = pick_data;
          grant_id_d = pick_idx;
          rr_ptr_d   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
        end
      end
      LOAD:  state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        if (cnt_q == CW'(FRAME_CYCLES - 1)) state_d = IDLE;
        else                                cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state, so they line up with the state they describe.
    uart_sel_d   = (state_d == LOAD) || (state_d == START);
    wr_d         = uart_sel_d;
    byte_ready_d = (state_d == LOAD);
    t_byte_d     = (state_d == START);
    busy_d       = (state_d != IDLE);
    tx_done_d    = (state_d == WAIT) && (cnt_d == CW'(FRAME_CYCLES - 1));
    data_out_d   = uart_sel_d ? data_reg_d : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      data_reg_q   <= '0;
      cnt_q        <= '0;
      uart_sel_q   <= 1'b0;
      wr_q         <= 1'b0;
      byte_ready_q <= 1'b0;
      t_byte_q     <= 1'b0;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      data_reg_q   <= data_reg_d;
      cnt_q        <= cnt_d;
      uart_sel_q   <= uart_sel_d;
      wr_q         <= wr_d;
      byte_ready_q <= byte_ready_d;
      t_byte_q     <= t_byte_d;
      busy_q       <= busy_d;
      tx_done_q    <= tx_done_d;
      data_out_q   <= data_out_d;
    end
  end

  assign uart_sel   = uart_sel_q;
  assign wr         = wr_q;
  assign byte_ready = byte_ready_q;
  assign t_byte     = t_byte_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;
  assign data_out   = data_out_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short frame (CLKS_PER_BIT=4, FRAME_CYCLES=40).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_uart_tx_arbiter;

  localparam int NREQ = 2;
  localparam int CPB  = 4;
  localparam int FB   = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        uart_sel, wr, byte_ready, t_byte, busy, tx_done;
  logic [7:0]  data_out;
  logic [0:0]  grant_id;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .uart_sel   (uart_sel),
    .wr         (wr),
    .data_out   (data_out),
    .byte_ready (byte_ready),
    .t_byte     (t_byte),
    .busy       (busy),
    .tx_done    (tx_done),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (req_ready !== 2'b00) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 2'b11; req_data = 16'h2211;
    repeat (3) tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    checks++; if ({uart_sel, wr, byte_ready, t_byte, busy, tx_done} !== 6'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {uart_sel, wr, byte_ready, t_byte, busy, tx_done}); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    req_valid = 2'b00; rst = 1'b1; #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_no_valid_ready: got %b want 00", req_ready); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    int bad;
    req_data[7:0] = 8'hA5; req_valid = 2'b01; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
    tick(); req_valid = 2'b00;
    checks++; if ({uart_sel, wr, byte_ready, t_byte, busy} !== 5'b11101) begin errors++;
      $display("FAIL single_load: sel/wr/br/tb/busy got %b want 11101", {uart_sel, wr, byte_ready, t_byte, busy}); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL single_load_data: got %h want a5", data_out); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL single_grant_id: got %0d want 0", grant_id); end
    tick();
    checks++; if ({uart_sel, wr, byte_ready, t_byte} !== 4'b1101) begin errors++;
      $display("FAIL single_start: sel/wr/br/tb got %b want 1101", {uart_sel, wr, byte_ready, t_byte}); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL single_start_data: got %h want a5", data_out); end
    bad = 0;
    for (int c = 3; c <= 41; c++) begin
      tick();
      if (tx_done !== 1'b0 || uart_sel !== 1'b0 || wr !== 1'b0 || data_out !== 8'h00 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL single_wait_phase: %0d bad cycles want 0", bad); end
    tick();
    checks++; if ({tx_done, busy} !== 2'b11) begin errors++; $display("FAIL single_tx_done: tx_done/busy got %b want 11", {tx_done, busy}); end
    tick();
    checks++; if ({tx_done, busy} !== 2'b00) begin errors++; $display("FAIL single_end: tx_done/busy got %b want 00", {tx_done, busy}); end
  endtask

  task automatic test_contention();
    bit found;
    int last;
    int exp;
    rst = 1'b0; req_valid = 2'b11; req_data = 16'h2211;
    tick();
    rst = 1'b1; #1;
    last = 0;
    for (int g = 0; g < 4; g++) begin
      exp = g % 2;
      if (g > 0) begin
        wait_ready(60, found);
        checks++; if (!found) begin errors++; $display("FAIL contention_timeout: grant %0d not seen", g); end
      end
      checks++; if (req_ready !== 2'(1 << exp)) begin errors++; $display("FAIL contention_ready%0d: got %b want %b", g, req_ready, 2'(1 << exp)); end
      if (g > 0) begin
        checks++; if (cyc - last != 43) begin errors++; $display("FAIL contention_spacing%0d: got %0d want 43", g, cyc - last); end
      end
      last = cyc;
      tick();
      checks++; if (grant_id !== 1'(exp)) begin errors++; $display("FAIL contention_grant_id%0d: got %0d want %0d", g, grant_id, exp); end
      checks++; if (data_out !== (exp == 1 ? 8'h22 : 8'h11)) begin errors++;
        $display("FAIL contention_data%0d: got %h want %h", g, data_out, (exp == 1 ? 8'h22 : 8'h11)); end
    end
    req_valid = 2'b00;
    wait_idle(60, found);
    checks++; if (!found) begin errors++; $display("FAIL contention_idle_timeout: busy still %b", busy); end
  endtask

  task automatic test_fairness();
    bit found;
    req_data = 16'h3311; req_valid = 2'b10; #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL fair_ready1: got %b want 10", req_ready); end
    tick();
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL fair_grant1: got %0d want 1", grant_id); end
    checks++; if (data_out !== 8'h33) begin errors++; $display("FAIL fair_data1: got %h want 33", data_out); end
    req_valid = 2'b11;
    wait_ready(60, found);
    checks++; if (!found) begin errors++; $display("FAIL fair_timeout: no grant after both valid"); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fair_ready0: got %b want 01", req_ready); end
    tick(); req_valid = 2'b00;
    checks++; if (grant_id !== 1'b0 || data_out !== 8'h11) begin errors++;
      $display("FAIL fair_grant0: id/data got %0d/%h want 0/11", grant_id, data_out); end
  endtask

  task automatic test_late_request();
    int bad;
    int n;
    repeat (9) tick();
    req_data[15:8] = 8'h44; req_valid = 2'b10; #1;
    bad = 0; n = 0;
    while (tx_done !== 1'b1 && n < 60) begin
      if (req_ready !== 2'b00) bad++;
      tick();
      n++;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL late_tx_done_time: got %0d cycles want 32", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL late_ready_in_wait: %0d bad cycles want 0", bad); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL late_ready_at_done: got %b want 00", req_ready); end
    tick();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL late_ready_idle: got %b want 10", req_ready); end
    tick(); req_valid = 2'b00;
    checks++; if (grant_id !== 1'b1 || data_out !== 8'h44) begin errors++;
      $display("FAIL late_grant: id/data got %0d/%h want 1/44", grant_id, data_out); end
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    int bad;
    rst = 1'b0; req_data = 16'h005A; req_valid = 2'b01;
    tick();
    rst = 1'b1; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_first_ready: got %b want 01", req_ready); end
    tick(); req_valid = 2'b00;
    repeat (19) tick();
    rst = 1'b0; #1;
    checks++; if ({uart_sel, wr, byte_ready, t_byte, busy, tx_done} !== 6'b0 || data_out !== 8'h00 || req_ready !== 2'b00) begin
      errors++; $display("FAIL rstmid_clear: ctrl %b data %h ready %b want all 0",
        {uart_sel, wr, byte_ready, t_byte, busy, tx_done}, data_out, req_ready); end
    repeat (2) tick();
    req_data = 16'h0077; req_valid = 2'b01; rst = 1'b1; #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_regrant: got %b want 01", req_ready); end
    tick(); req_valid = 2'b00;
    checks++; if (byte_ready !== 1'b1 || data_out !== 8'h77) begin errors++;
      $display("FAIL rstmid_load: br/data got %b/%h want 1/77", byte_ready, data_out); end
    bad = 0;
    repeat (30) begin
      tick();
      if (tx_done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_stale_tx_done: %0d pulses want 0", bad); end
    wait_idle(60, found);
    checks++; if (!found) begin errors++; $display("FAIL rstmid_idle_timeout: busy still %b", busy); end
  endtask

  task automatic test_idle_stability();
    int bad;
    req_valid = 2'b00;
    bad = 0;
    repeat (100) begin
      tick();
      if ({busy, uart_sel, wr, t_byte, byte_ready, tx_done} !== 6'b0 || data_out !== 8'h00 || req_ready !== 2'b00) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_stability: %0d active cycles want 0", bad); end
  endtask

  initial begin
    rst = 1'b0; req_valid = 2'b00; req_data = 16'h0000;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_late_request();
    test_reset_mid_frame();
    test_idle_stability();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among NREQ byte requesters, such as the CPU store path and a debug/trace port. It arbitrates round-robin, drives the transmitter's select, write, data, byte-ready and transmit-byte inputs in the order the transmit controller expects, then holds off the next grant until the serial frame has left the line. It sits between the requesters and the UART top, and it is the only agent allowed to drive the UART.

## Interface
Parameters:
- NREQ, 2: number of requesters (≥2).
- CLKS_PER_BIT, 868: clock cycles per baud period (100 MHz / 115200).
- FRAME_BITS, 10: bits per frame (start + 8 data + stop).

Ports:
- clk  in  1  system clock, all flops rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  requester i has a byte pending; held until accepted.
- req_data  in  NREQ×8  packed bytes, requester i at [8i+7:8i].
- req_ready  out  NREQ  one-hot acceptance; transfer when valid & ready.
- uart_sel  out  1  UART select.
- wr  out  1  UART write strobe.
- data_out  out  8  byte to UART data_in.
- byte_ready  out  1  byte-ready pulse to the UART controller.
- t_byte  out  1  transmit-byte pulse to the UART controller.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse when a frame's airtime has elapsed.
- grant_id  out  $clog2(NREQ)  index of the last accepted requester.

## Operation
- FSM states IDLE → LOAD → START → WAIT → IDLE.
- IDLE
  - req_ready[i] = (state==IDLE) & (i == rr_pick), combinational.
  - rr_pick is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - On the handshake: capture req_data[i] into data_reg and i into grant_id; set rr_ptr = (i+1) mod NREQ; go to LOAD.
  - With no valid requester, stay in IDLE; rr_ptr is unchanged.
- LOAD (1 cycle): uart_sel=1, wr=1, byte_ready=1, data_out=data_reg.
- START (1 cycle): uart_sel=1, wr=1, t_byte=1, data_out=data_reg.
- WAIT
  - uart_sel=0, wr=0, data_out=0.
  - Counter runs from 0 to FRAME_CYCLES−1, where FRAME_CYCLES = CLKS_PER_BIT×FRAME_BITS.
  - At the terminal count: tx_done=1 for that cycle, next state IDLE, counter cleared.
- Counter width is $clog2(FRAME_CYCLES). It never wraps, because it is cleared on leaving WAIT.
- data_out is 0 whenever uart_sel & wr is 0.
- req_valid may drop before acceptance; the arbiter re-evaluates rr_pick every IDLE cycle. Requests presented outside IDLE are simply not granted.
- Simultaneous requests: exactly one grant per frame, and no requester waits more than NREQ−1 frames.

## Timing
- All of the following are 0 at reset and asynchronously while rst=0: state=IDLE, rr_ptr=0, counter=0, data_reg=0, grant_id=0, and outputs uart_sel, wr, data_out, byte_ready, t_byte, busy, tx_done.
- req_ready is combinational. With rst=0, or with rst=1 and no valid requester, it is 0. It is the only combinational output.
- Handshake in cycle H produces:
  - LOAD in H+1.
  - START in H+2.
  - WAIT from H+3 through H+2+FRAME_CYCLES.
  - tx_done in H+2+FRAME_CYCLES.
  - Earliest next handshake in H+3+FRAME_CYCLES.
- Back-to-back throughput is one byte per FRAME_CYCLES+3 cycles.
- Reset asserted mid-frame aborts the sequence: no tx_done and no pending grant. After release, the FSM starts in IDLE with rr_ptr=0.

## Structure
- Package uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} uart_arb_state_t.
  - The default FRAME_BITS constant.
- Sub-module rr_arbiter (parameter NREQ) is purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot pick, pick index, any_valid.
- The FSM, counter, data_reg and rr_ptr stay in uart_tx_arbiter.

## Test plan
Bench uses CLKS_PER_BIT=4, so FRAME_CYCLES=40.
- Single request: req 0 presents 0xA5 with valid held. Required: req_ready[0] in the same cycle; byte_ready with data_out=0xA5 at H+1; t_byte at H+2; tx_done at H+42; busy low at H+43.
- Contention: both requesters valid from reset, req0 0x11 and req1 0x22. Required: grants alternate 0,1,0,1 with 43-cycle spacing; grant_id follows; data_out matches the granted byte.
- Pointer fairness: only req1 valid, with 0x33. Required: grant 1 and rr_ptr=0. Then both valid: req0 granted next.
- Late request: raise req_valid[1] during WAIT. Required: req_ready stays 0 until IDLE, then the grant comes the first IDLE cycle after tx_done.
- Reset mid-frame: assert rst at H+20. Required: all outputs 0 immediately and no tx_done. After release with req0 valid, a new grant comes in the first cycle.
- Idle stability: no valid for 100 cycles. Required: busy, uart_sel, wr and t_byte stay 0; data_out stays 0x00.
